// File: rtl/r3sdf_stage.sv
// rtl/r3sdf_stage.sv - radix-3 single-delay-feedback DIF butterfly stage
// Two D-deep complex delay lines addressed by n; emits a twiddle exponent per output.
module r3sdf_stage #(
  parameter int WIDTH = 18,
  parameter int D     = 81,
  parameter int SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] di_re,
  input  logic signed [WIDTH-1:0] di_im,
  input  logic                    di_en,
  output logic                    di_rdy,
  output logic signed [WIDTH-1:0] do_re,
  output logic signed [WIDTH-1:0] do_im,
  output logic                    do_en,
  output logic [7:0]              tw_idx
);

  localparam int NB    = 81 / D;
  localparam int AW    = (D > 1) ? $clog2(D) : 1;
  localparam int BW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int FW    = $clog2(2 * D);
  localparam int DEPTH = 2 ** AW;
  localparam int IW    = WIDTH + 3;

  localparam logic [1:0] S_P0 = 2'd0;
  localparam logic [1:0] S_P1 = 2'd1;
  localparam logic [1:0] S_P2 = 2'd2;
  localparam logic [1:0] S_FL = 2'd3;

  typedef logic signed [IW-1:0]    iw_t;
  typedef logic signed [WIDTH-1:0] w_t;

  localparam iw_t SMAX = iw_t'((2 ** (WIDTH - 1)) - 1);
  localparam iw_t SMIN = -SMAX - iw_t'(1);

  // v * sqrt(3)/2 in Q15, floored
  function automatic iw_t pmul(input iw_t v);
    logic signed [IW+16:0] pr;
    pr = v * $signed(17'sd28378);
    return pr[IW+14:15];
  endfunction

  function automatic w_t scale_sat(input iw_t v);
    iw_t s;
    s = v >>> SHIFT;
    if (s > SMAX)      return SMAX[WIDTH-1:0];
    else if (s < SMIN) return SMIN[WIDTH-1:0];
    else               return s[WIDTH-1:0];
  endfunction

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] n_q, n_d;
  logic [BW-1:0] blk_q, blk_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  w_t            do_re_q, do_re_d, do_im_q, do_im_d;
  logic          do_en_q, do_en_d;
  logic [7:0]    tw_q, tw_d;

  w_t dl1_re [0:DEPTH-1];
  w_t dl1_im [0:DEPTH-1];
  w_t dl2_re [0:DEPTH-1];
  w_t dl2_im [0:DEPTH-1];

  logic          acc, dl1_we, dl2_we, fl_first;
  logic [AW-1:0] fl_addr, rd_addr;
  w_t            dl1_wr_re, dl1_wr_im, dl2_wr_re, dl2_wr_im;
  iw_t           x0r, x0i, x1r, x1i, x2r, x2i, ar, ai, br, bi, hr, hi, pbr, pbi;
  w_t            s0r, s0i, s1r, s1i, s2r, s2i;

  assign di_rdy   = (state_q != S_FL);
  assign acc      = di_en && di_rdy;
  assign fl_first = (fcnt_q < FW'(D));
  assign fl_addr  = fl_first ? AW'(fcnt_q) : AW'(fcnt_q - FW'(D));
  assign rd_addr  = (state_q == S_FL) ? fl_addr : n_q;

  always_comb begin
    x0r = iw_t'(dl1_re[rd_addr]);
    x0i = iw_t'(dl1_im[rd_addr]);
    x1r = iw_t'(dl2_re[rd_addr]);
    x1i = iw_t'(dl2_im[rd_addr]);
    x2r = iw_t'(di_re);
    x2i = iw_t'(di_im);
    ar  = x1r + x2r;
    ai  = x1i + x2i;
    br  = x1r - x2r;
    bi  = x1i - x2i;
    hr  = ar >>> 1;
    hi  = ai >>> 1;
    pbr = pmul(br);
    pbi = pmul(bi);
    s0r = scale_sat(x0r + ar);
    s0i = scale_sat(x0i + ai);
    s1r = scale_sat(x0r - hr + pbi);
    s1i = scale_sat(x0i - hi - pbr);
    s2r = scale_sat(x0r - hr - pbi);
    s2i = scale_sat(x0i - hi + pbr);
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    blk_d     = blk_q;
    fcnt_d    = fcnt_q;
    do_re_d   = '0;
    do_im_d   = '0;
    do_en_d   = 1'b0;
    tw_d      = '0;
    dl1_we    = 1'b0;
    dl2_we    = 1'b0;
    dl1_wr_re = di_re;
    dl1_wr_im = di_im;
    dl2_wr_re = di_re;
    dl2_wr_im = di_im;
    case (state_q)
      S_P0, S_P1: begin
        if (acc) begin
          dl1_we = (state_q == S_P0);
          dl2_we = (state_q == S_P1);
          // block 0 delay lines hold nothing from a previous block yet
          if (blk_q != '0) begin
            do_en_d = 1'b1;
            do_re_d = (state_q == S_P0) ? dl1_re[n_q] : dl2_re[n_q];
            do_im_d = (state_q == S_P0) ? dl1_im[n_q] : dl2_im[n_q];
            tw_d    = (state_q == S_P0) ? 8'(n_q) : (8'(n_q) << 1);
          end
          if (n_q == AW'(D - 1)) begin
            n_d     = '0;
            state_d = (state_q == S_P0) ? S_P1 : S_P2;
          end else begin
            n_d = n_q + 1'b1;
          end
        end
      end
      S_P2: begin
        if (acc) begin
          dl1_we    = 1'b1;
          dl2_we    = 1'b1;
          dl1_wr_re = s1r;
          dl1_wr_im = s1i;
          dl2_wr_re = s2r;
          dl2_wr_im = s2i;
          do_en_d   = 1'b1;
          do_re_d   = s0r;
          do_im_d   = s0i;
          if (n_q == AW'(D - 1)) begin
            n_d = '0;
            if (blk_q == BW'(NB - 1)) begin
              state_d = S_FL;
            end else begin
              blk_d   = blk_q + 1'b1;
              state_d = S_P0;
            end
          end else begin
            n_d = n_q + 1'b1;
          end
        end
      end
      default: begin
        do_en_d = 1'b1;
        do_re_d = fl_first ? dl1_re[fl_addr] : dl2_re[fl_addr];
        do_im_d = fl_first ? dl1_im[fl_addr] : dl2_im[fl_addr];
        tw_d    = fl_first ? 8'(fl_addr) : (8'(fl_addr) << 1);
        if (fcnt_q == FW'(2 * D - 1)) begin
          fcnt_d  = '0;
          blk_d   = '0;
          state_d = S_P0;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_P0;
      n_q     <= '0;
      blk_q   <= '0;
      fcnt_q  <= '0;
      do_re_q <= '0;
      do_im_q <= '0;
      do_en_q <= 1'b0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      blk_q   <= blk_d;
      fcnt_q  <= fcnt_d;
      do_re_q <= do_re_d;
      do_im_q <= do_im_d;
      do_en_q <= do_en_d;
      tw_q    <= tw_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && dl1_we) begin
      dl1_re[n_q] <= dl1_wr_re;
      dl1_im[n_q] <= dl1_wr_im;
    end
    if (!rst && dl2_we) begin
      dl2_re[n_q] <= dl2_wr_re;
      dl2_im[n_q] <= dl2_wr_im;
    end
  end

  assign do_re  = do_re_q;
  assign do_im  = do_im_q;
  assign do_en  = do_en_q;
  assign tw_idx = tw_q;

endmodule

// File: tb/tb_r3sdf_stage.sv
// tb/tb_r3sdf_stage.sv - scoreboard bench for r3sdf_stage at D=1 and D=81
module tb_r3sdf_stage;

  typedef struct {
    int re;
    int im;
    int tw;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               sel;
  logic signed [17:0] di_re, di_im;
  logic               di_en;
  logic               en1, en81, rdy1, rdy81, rdy_sel;
  logic signed [17:0] o1_re, o1_im, o81_re, o81_im;
  logic               o1_en, o81_en;
  logic [7:0]         o1_tw, o81_tw;

  assign en1     = di_en & ~sel;
  assign en81    = di_en & sel;
  assign rdy_sel = sel ? rdy81 : rdy1;

  r3sdf_stage #(.WIDTH(18), .D(1), .SHIFT(0)) u_d1 (
    .clk(clk), .rst(rst), .di_re(di_re), .di_im(di_im), .di_en(en1), .di_rdy(rdy1),
    .do_re(o1_re), .do_im(o1_im), .do_en(o1_en), .tw_idx(o1_tw)
  );

  r3sdf_stage #(.WIDTH(18), .D(81), .SHIFT(0)) u_d81 (
    .clk(clk), .rst(rst), .di_re(di_re), .di_im(di_im), .di_en(en81), .di_rdy(rdy81),
    .do_re(o81_re), .do_im(o81_im), .do_en(o81_en), .tw_idx(o81_tw)
  );

  exp_t q1[$];
  exp_t q81[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   oc1 = 0;
  int   oc81 = 0;
  bit   mon_on = 1'b0;
  int   xr[243];
  int   xi[243];

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic mon(input int inst, input logic en, input logic signed [17:0] re,
                     input logic signed [17:0] im, input logic [7:0] tw);
    exp_t e;
    if (en === 1'b1) begin
      if ((inst == 1 && q1.size() == 0) || (inst == 81 && q81.size() == 0)) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_output D=%0d: observed do_en=1 expected no output", inst);
      end else begin
        if (inst == 1) e = q1.pop_front();
        else           e = q81.pop_front();
        chk($sformatf("do_re D=%0d", inst), re, e.re);
        chk($sformatf("do_im D=%0d", inst), im, e.im);
        chk($sformatf("tw_idx D=%0d", inst), tw, e.tw);
        if (inst == 81) begin
          if (oc81 == 85)  chk("tw_idx_out85", tw, 4);
          if (oc81 == 166) chk("tw_idx_out166", tw, 8);
          oc81++;
        end else begin
          oc1++;
        end
      end
    end else begin
      chk($sformatf("do_en D=%0d", inst), en, 0);
      chk($sformatf("idle_re D=%0d", inst), re, 0);
      chk($sformatf("idle_im D=%0d", inst), im, 0);
      chk($sformatf("idle_tw D=%0d", inst), tw, 0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      mon(1, o1_en, o1_re, o1_im, o1_tw);
      mon(81, o81_en, o81_re, o81_im, o81_tw);
    end
  end

  function automatic longint pm(input longint v);
    return (v * 28378) >>> 15;
  endfunction

  function automatic int sat(input longint v);
    if (v > 131071)  return 131071;
    if (v < -131072) return -131072;
    return int'(v);
  endfunction

  task automatic push_exp(input int dd, input int re, input int im, input int tw);
    exp_t e;
    e.re = re;
    e.im = im;
    e.tw = tw;
    if (dd == 1) q1.push_back(e);
    else         q81.push_back(e);
  endtask

  // golden radix-3 DIF: per block y0 run, y1 run (W^n), y2 run (W^2n)
  task automatic model(input int dd);
    longint x0r, x0i, x1r, x1i, x2r, x2i, ar, ai, br, bi;
    int y1r[81], y1i[81], y2r[81], y2i[81];
    for (int b = 0; b < 81 / dd; b++) begin
      for (int n = 0; n < dd; n++) begin
        x0r = xr[3*dd*b + n];        x0i = xi[3*dd*b + n];
        x1r = xr[3*dd*b + dd + n];   x1i = xi[3*dd*b + dd + n];
        x2r = xr[3*dd*b + 2*dd + n]; x2i = xi[3*dd*b + 2*dd + n];
        ar = x1r + x2r; ai = x1i + x2i;
        br = x1r - x2r; bi = x1i - x2i;
        push_exp(dd, sat(x0r + ar), sat(x0i + ai), 0);
        y1r[n] = sat(x0r - (ar >>> 1) + pm(bi));
        y1i[n] = sat(x0i - (ai >>> 1) - pm(br));
        y2r[n] = sat(x0r - (ar >>> 1) - pm(bi));
        y2i[n] = sat(x0i - (ai >>> 1) + pm(br));
      end
      for (int n = 0; n < dd; n++) push_exp(dd, y1r[n], y1i[n], n);
      for (int n = 0; n < dd; n++) push_exp(dd, y2r[n], y2i[n], 2 * n);
    end
  endtask

  task automatic send(input int re, input int im);
    int w;
    di_re = 18'(re);
    di_im = 18'(im);
    di_en = 1'b1;
    w = 0;
    while (rdy_sel !== 1'b1 && w < 400) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 400) begin
      vectors++;
      miscompares++;
      $error("FAIL rdy_timeout: observed di_rdy=0 for %0d cycles expected 1", w);
    end
    @(posedge clk); #1;
    di_en = 1'b0;
  endtask

  task automatic send_part(input int count, input int gaps_max);
    for (int i = 0; i < count; i++) begin
      if (gaps_max > 0 && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, gaps_max)) begin @(posedge clk); #1; end
      send(xr[i], xi[i]);
    end
  endtask

  task automatic run_frame(input int dd, input int gaps_max);
    int cnt;
    oc1 = 0;
    oc81 = 0;
    send_part(243, gaps_max);
    // junk offered throughout the flush must be ignored
    cnt = 0;
    di_en = 1'b1;
    di_re = 18'sd12345;
    di_im = -18'sd777;
    while (rdy_sel === 1'b0 && cnt < 400) begin
      @(posedge clk); #1;
      cnt++;
    end
    di_en = 1'b0;
    chk($sformatf("flush_cycles D=%0d", dd), cnt, 2 * dd);
    repeat (3) begin @(posedge clk); #1; end
    if (dd == 1) begin
      chk("queue_drained D=1", q1.size(), 0);
      chk("out_count D=1", oc1, 243);
    end else begin
      chk("queue_drained D=81", q81.size(), 0);
      chk("out_count D=81", oc81, 243);
    end
  endtask

  task automatic fill(input int re, input int im);
    for (int i = 0; i < 243; i++) begin
      xr[i] = re;
      xi[i] = im;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 243; i++) begin
      xr[i] = int'($urandom_range(0, 262143)) - 131072;
      xi[i] = int'($urandom_range(0, 262143)) - 131072;
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: observed simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    sel = 1'b0;
    di_en = 1'b0;
    di_re = '0;
    di_im = '0;

    @(posedge clk); #1;
    mon_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      di_en = ~di_en;
      sel = ~sel;
      di_re = 18'sd5000;
      @(posedge clk); #1;
      chk("rst_rdy D=1", rdy1, 1);
      chk("rst_rdy D=81", rdy81, 1);
    end
    rst = 1'b0;
    di_en = 1'b0;
    sel = 1'b0;
    @(posedge clk); #1;

    // impulse
    fill(0, 0);
    xr[0] = 1000;
    for (int i = 0; i < 243; i++) push_exp(1, (i < 3) ? 1000 : 0, 0, 0);
    run_frame(1, 0);

    // constant
    fill(300, 0);
    for (int b = 0; b < 81; b++) begin
      push_exp(1, 900, 0, 0);
      push_exp(1, 0, 0, 0);
      push_exp(1, 0, 0, 0);
    end
    run_frame(1, 2);

    // sqrt(3) path
    fill(0, 0);
    xr[1] = 1000;
    xr[2] = -1000;
    push_exp(1, 0, 0, 0);
    push_exp(1, 0, -1732, 0);
    push_exp(1, 0, 1732, 0);
    for (int i = 3; i < 243; i++) push_exp(1, 0, 0, 0);
    run_frame(1, 0);

    // saturation
    fill(131071, 131071);
    for (int b = 0; b < 81; b++) begin
      push_exp(1, 131071, 131071, 0);
      push_exp(1, 0, 0, 0);
      push_exp(1, 0, 0, 0);
    end
    run_frame(1, 1);

    // random full-scale D=1
    fill_rand();
    model(1);
    run_frame(1, 2);

    // D=81 random with gaps
    sel = 1'b1;
    fill_rand();
    model(81);
    run_frame(81, 3);

    // reset mid-frame, then a fresh frame
    fill_rand();
    model(81);
    send_part(100, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    q81.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_rdy D=81", rdy81, 1);
    fill_rand();
    model(81);
    run_frame(81, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/r3sdf_stage.md
# r3sdf_stage

Streaming radix-3 decimation-in-frequency butterfly stage with single-delay feedback (R3SDF) for the 243-point (3^5) FFT. Five instances, D = 81, 27, 9, 3, 1, are cascaded with twiddle multipliers between them. The D = 1 instance feeds the 243-point base-3 digit-reversal reorder buffer. The stage performs the butterfly only and emits a twiddle exponent index for the following twiddle multiplier.

## Interface
- WIDTH, 18, signed sample width for input and output (re and im each)
- D, 81, delay length; legal values 81, 27, 9, 3, 1; block size 3D; 81/D blocks per frame
- SHIFT, 0, arithmetic right shift applied before saturation; legal 0..2
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- di_re, di_im  in  WIDTH  signed input sample
- di_en  in  1  input valid; accepted only when di_rdy = 1
- di_rdy  out  1  stage can accept input; low during FLUSH
- do_re, do_im  out  WIDTH  signed butterfly output, registered
- do_en  out  1  output valid
- tw_idx  out  8  twiddle exponent m·n for this output; the multiplier uses W_{3D}^{tw_idx}

## Operation
- Two delay lines (DL1, DL2), each D words of complex data. Contents are not reset.
- Counters: n (0..D-1), blk (0..81/D-1), fcnt (0..2D-1).
- State P0, on accept: DL1 receives the input; DL1's old head goes to output; advance n. At n = D-1, go to P1.
- State P1, on accept: DL2 receives the input; DL2's old head goes to output; advance n. At n = D-1, go to P2.
- State P0/P1 output rules:
  - In blk 0, outputs are suppressed (do_en = 0).
  - In later blocks, P0 emits y1[n] of the previous block with tw_idx = n.
  - In later blocks, P1 emits y2[n] of the previous block with tw_idx = 2n.
- State P2, on accept: compute the butterfly with x0 = DL1 head, x1 = DL2 head, x2 = input.
  - Emit y0[n] with tw_idx = 0.
  - Write y1[n] into DL1 and y2[n] into DL2.
  - At n = D-1: if blk = last, go to FLUSH; otherwise blk++ and go to P0.
- FLUSH lasts 2D cycles with di_rdy = 0.
  - Emits y1[0..D-1], then y2[0..D-1] of the last block, one per cycle, with tw_idx as in P0/P1.
  - Then blk = 0, state P0, di_rdy = 1.
- Per frame: exactly 243 outputs, in order y0 block, y1 block, y2 block for each block.
- Butterfly arithmetic:
  - Internal width WIDTH+3; s = 28378 (√3/2 in Q15).
  - a = x1+x2, b = x1−x2.
  - y0 = x0 + a.
  - y1re = x0re − (ar>>>1) + P(bi); y1im = x0im − (ai>>>1) − P(br).
  - y2re = x0re − (ar>>>1) − P(bi); y2im = x0im − (ai>>>1) + P(br).
  - P(v) = (v·28378)>>>15; all shifts floor.
- Output scaling: each result is >>>SHIFT (floor), then saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1]. y1/y2 are stored in the delay lines already scaled and saturated.

## Timing
- Reset values: do_re = do_im = 0, do_en = 0, tw_idx = 0, di_rdy = 1, state P0, n = blk = fcnt = 0.
- Latency: do_* is valid the cycle after the accepting di_en edge.
  - do_en is 0 in cycles without an accept, except during FLUSH, where it is 1 on every cycle.
- Gaps in di_en within a frame are allowed; state advances only on accept.
- When do_en = 0, do_re/do_im/tw_idx hold 0.
- di_en while di_rdy = 0 is ignored; no state change and no write.
- di_rdy falls the cycle after the frame's 243rd accept and rises after the 2D-th flush output.
  - A frame may start on the cycle di_rdy returns to 1.
- Reset mid-frame or mid-flush: all state returns to reset values the next cycle; pending outputs are discarded.
- tw_idx maximum is 2(D−1) = 160, which fits in 8 bits.

## Test plan
- Reset: hold rst for 3 cycles with di_en toggling. Required: do_en = 0, do_re = do_im = tw_idx = 0, di_rdy = 1.
- Impulse, D=1, SHIFT=0: 243 samples, x[0] = 1000+0j, rest 0.
  - First three outputs are 1000, 1000, 1000; the remaining 240 are 0.
  - tw_idx is always 0.
  - Exactly 243 do_en pulses; di_rdy is low for 2 cycles.
- Constant, D=1, SHIFT=0: all samples 300+0j. Every block yields y0 = 900, y1 = 0, y2 = 0.
- √3 path, D=1: block (0, 1000, −1000), imaginary parts 0.
  - y1 = 0 − 1732j.
  - y2 = 0 + 1732j.
- Saturation, WIDTH=18, SHIFT=0: all inputs 131071+131071j. y0 = 131071+131071j (saturated); y1 = y2 = 0.
- D=81 frame with random di_en gaps:
  - Results match a golden radix-3 DIF model bit-exactly.
  - Output 85 (y1, n=4) has tw_idx = 4; output 166 (y2, n=4) has tw_idx = 8.
  - FLUSH lasts 162 cycles; di_en asserted during FLUSH is ignored.
  - rst asserted mid-frame, followed by a new frame, gives correct results for the new frame.
